// File: rtl/bg2_shift_scheduler_pkg.sv
// bg2_shift_scheduler_pkg: shared constants and FSM state type for the BG2 shift scheduler
package bg2_shift_scheduler_pkg;
  localparam int BG2_MAX_TRANSFORMS = 197;
  localparam int ZC_MIN = 2;
  localparam int ZC_MAX = 384;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, LOAD, MOD, OUT, DONE} sched_state_t;
endpackage

// File: rtl/bg2_shift_scheduler_mod_unit.sv
// bg2_shift_scheduler_mod_unit: VW-cycle restoring remainder, rem = value mod zc
module bg2_shift_scheduler_mod_unit #(
  parameter int VW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [VW-1:0] value,
  input  logic [VW-1:0] zc,
  output logic [VW-1:0] rem,
  output logic          done
);
  localparam int KW = $clog2(VW);
  logic [VW-1:0]   r;
  logic [KW-1:0]   k;
  logic            act;
  logic [2*VW-1:0] sub;
  logic            fit;
  // Divisor is widened before shifting so zc<<k never wraps
  assign sub  = {{VW{1'b0}}, zc} << k;
  assign fit  = sub <= {{VW{1'b0}}, r};
  assign done = act && k == '0;
  assign rem  = r;
  always_ff @(posedge clk) begin
    if (reset) begin
      r   <= '0;
      k   <= '0;
      act <= 1'b0;
    end else if (start) begin
      r   <= value;
      k   <= KW'(VW - 1);
      act <= 1'b1;
    end else if (act) begin
      r   <= fit ? r - sub[VW-1:0] : r;
      k   <= k - 1'b1;
      act <= k != '0;
    end
  end
endmodule

// File: rtl/bg2_shift_scheduler.sv
// bg2_shift_scheduler: reads one BG2 ROM row set per job and streams entries mod Zc downstream
module bg2_shift_scheduler
  import bg2_shift_scheduler_pkg::*;
#(
  parameter int N_ENT = BG2_MAX_TRANSFORMS,
  parameter int VW    = 9,
  parameter int IW    = $clog2(N_ENT),
  parameter int TMO   = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [2:0]                ils_sel,
  input  logic [VW-1:0]             zc,
  output logic                      rd_en2,
  output logic [2:0]                ils_selected,
  input  logic [N_ENT-1:0][VW-1:0]  bg2_out,
  input  logic                      bg2_valid,
  output logic                      shift_valid,
  input  logic                      shift_ready,
  output logic [VW-1:0]             shift_val,
  output logic [IW-1:0]             shift_idx,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);
  localparam int TW = $clog2(TMO + 1);
  sched_state_t              st, nxt;
  logic [IW-1:0]             idx;
  logic [TW-1:0]             tmo_cnt;
  logic [VW-1:0]             zc_q;
  logic [2:0]                ils_q;
  logic [N_ENT-1:0][VW-1:0]  ent;
  logic                      err_q;
  logic                      zc_ok, accept, tmo_hit, last, mod_done;
  assign zc_ok   = zc >= VW'(ZC_MIN) && zc <= VW'(ZC_MAX);
  assign accept  = st == IDLE && start && zc_ok;
  assign tmo_hit = st == WAIT && !bg2_valid && tmo_cnt == TW'(TMO - 1);
  assign last    = idx == IW'(N_ENT - 1);
  assign rd_en2       = st == REQ;
  assign ils_selected = ils_q;
  assign shift_valid  = st == OUT;
  assign shift_idx    = idx;
  assign busy         = st != IDLE && st != DONE;
  assign done         = st == DONE;
  assign err          = err_q;
  bg2_shift_scheduler_mod_unit #(.VW(VW)) u_mod (
    .clk   (clk),
    .reset (reset),
    .start (st == LOAD),
    .value (ent[idx]),
    .zc    (zc_q),
    .rem   (shift_val),
    .done  (mod_done)
  );
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = accept ? REQ : IDLE;
      REQ:     nxt = WAIT;
      WAIT:    nxt = bg2_valid ? LOAD : tmo_hit ? IDLE : WAIT;
      LOAD:    nxt = MOD;
      MOD:     nxt = mod_done ? OUT : MOD;
      OUT:     nxt = !shift_ready ? OUT : last ? DONE : LOAD;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= IDLE;
      idx     <= '0;
      tmo_cnt <= '0;
      zc_q    <= '0;
      ils_q   <= '0;
      ent     <= '0;
      err_q   <= 1'b0;
    end else begin
      st      <= nxt;
      err_q   <= (st == IDLE && start && !zc_ok) || tmo_hit;
      tmo_cnt <= st == WAIT ? tmo_cnt + 1'b1 : '0;
      if (accept) begin
        zc_q  <= zc;
        ils_q <= ils_sel;
      end
      // ROM data is only guaranteed during bg2_valid, so keep a private copy
      if (st == WAIT && bg2_valid) begin
        ent <= bg2_out;
        idx <= '0;
      end
      if (st == OUT && shift_ready && !last) idx <= idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_bg2_shift_scheduler.sv
// tb_bg2_shift_scheduler: directed self-checking bench for bg2_shift_scheduler
module tb_bg2_shift_scheduler;
  localparam int N = 8;
  logic              clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [2:0]        ils_sel = '0, ils_selected;
  logic [8:0]        zc = '0, shift_val;
  logic              rd_en2, bg2_valid = 1'b0, shift_valid, shift_ready = 1'b0;
  logic [N-1:0][8:0] bg2_out = '0;
  logic [2:0]        shift_idx;
  logic              busy, done, err;
  int checks = 0, errors = 0;
  logic [8:0] rom [N] = '{9'd250, 9'd7, 9'd255, 9'd0, 9'd383, 9'd100, 9'd1, 9'd200};
  int n_xfer, n_done, rd_extra, stab_err, first_valid, done_c;
  logic [8:0] xv [N+4];
  logic [2:0] xi [N+4];
  int xcyc [N+4];
  logic rd_seen, busy_seen, busy_at_done;
  logic [2:0] ils_seen;

  bg2_shift_scheduler #(.N_ENT(N), .VW(9), .IW(3), .TMO(15)) dut (
    .clk(clk), .reset(reset), .start(start), .ils_sel(ils_sel), .zc(zc),
    .rd_en2(rd_en2), .ils_selected(ils_selected), .bg2_out(bg2_out), .bg2_valid(bg2_valid),
    .shift_valid(shift_valid), .shift_ready(shift_ready), .shift_val(shift_val),
    .shift_idx(shift_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic run_job(input logic [8:0] z, input logic [2:0] ils, input bit rnd);
    logic pv, r;
    logic [8:0] pval;
    logic [2:0] pidx;
    n_xfer = 0; n_done = 0; rd_extra = 0; stab_err = 0; first_valid = -1; done_c = -1;
    busy_at_done = 1'b1; pv = 1'b0; pval = '0; pidx = '0;
    @(negedge clk); start = 1'b1; zc = z; ils_sel = ils;
    @(negedge clk); start = 1'b0;
    rd_seen = rd_en2; ils_seen = ils_selected; busy_seen = busy;
    zc = 9'd5; ils_sel = 3'd7;
    @(negedge clk);
    for (int i = 0; i < N; i++) bg2_out[i] = rom[i];
    bg2_valid = 1'b1;
    for (int c = 1; c < 600; c++) begin
      @(negedge clk);
      bg2_valid = 1'b0; bg2_out = '1;
      start = (c == 3);
      if (rd_en2) rd_extra++;
      if (done) begin
        n_done++; busy_at_done = busy;
        if (done_c < 0) begin done_c = c; start = 1'b1; end
      end
      if (shift_valid) begin
        if (first_valid < 0) first_valid = c;
        if (pv && (shift_val !== pval || shift_idx !== pidx)) stab_err++;
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      shift_ready = r;
      if (shift_valid && r) begin
        if (n_xfer < N + 4) begin xv[n_xfer] = shift_val; xi[n_xfer] = shift_idx; xcyc[n_xfer] = c; end
        n_xfer++; pv = 1'b0;
      end else begin
        pv = shift_valid; pval = shift_val; pidx = shift_idx;
      end
      if (done_c >= 0 && c >= done_c + 5) break;
    end
    start = 1'b0; shift_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({rd_en2, ils_selected, shift_valid, shift_val, shift_idx, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%b ils=%0d sv=%b val=%0d idx=%0d busy=%b done=%b err=%b, want all 0",
               rd_en2, ils_selected, shift_valid, shift_val, shift_idx, busy, done, err);
    end
  endtask

  task automatic test_first_entry();
    run_job(9'd384, 3'd0, 1'b0);
    checks++; if (rd_seen !== 1'b1 || busy_seen !== 1'b1) begin errors++; $display("FAIL req_cycle: rd_en2=%b busy=%b, want 1 1", rd_seen, busy_seen); end
    checks++; if (ils_seen !== 3'd0) begin errors++; $display("FAIL ils_selected: got %0d want 0", ils_seen); end
    checks++; if (first_valid !== 11) begin errors++; $display("FAIL first_latency: valid at %0d want 11", first_valid); end
    checks++; if (xv[0] !== 9'd250 || xi[0] !== 3'd0) begin errors++; $display("FAIL entry0: val=%0d idx=%0d want 250 0", xv[0], xi[0]); end
    checks++; if (xcyc[1] - xcyc[0] !== 11) begin errors++; $display("FAIL entry_period: got %0d want 11", xcyc[1] - xcyc[0]); end
    checks++; if (n_xfer !== N || n_done !== 1) begin errors++; $display("FAIL job_count: xfers=%0d dones=%0d want %0d 1", n_xfer, n_done, N); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (xi[i] !== 3'(i) || xv[i] !== rom[i] % 9'd384) begin
        errors++; $display("FAIL z384_entry%0d: val=%0d idx=%0d want %0d %0d", i, xv[i], xi[i], rom[i] % 9'd384, i);
      end
    end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL busy_in_done: got %b want 0", busy_at_done); end
    checks++; if (rd_extra !== 0) begin errors++; $display("FAIL start_while_busy: extra rd_en2=%0d want 0", rd_extra); end
  endtask

  task automatic test_mod_values();
    run_job(9'd2, 3'd1, 1'b0);
    checks++; if (xv[1] !== 9'd1) begin errors++; $display("FAIL z2_e7: got %0d want 1", xv[1]); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (xv[i] !== rom[i] % 9'd2) begin errors++; $display("FAIL z2_entry%0d: got %0d want %0d", i, xv[i], rom[i] % 9'd2); end
    end
    run_job(9'd13, 3'd4, 1'b0);
    checks++; if (xv[2] !== 9'd8) begin errors++; $display("FAIL z13_e255: got %0d want 8", xv[2]); end
    checks++; if (xv[3] !== 9'd0) begin errors++; $display("FAIL z13_e0: got %0d want 0", xv[3]); end
    checks++; if (ils_seen !== 3'd4) begin errors++; $display("FAIL ils4: got %0d want 4", ils_seen); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (xv[i] !== rom[i] % 9'd13) begin errors++; $display("FAIL z13_entry%0d: got %0d want %0d", i, xv[i], rom[i] % 9'd13); end
    end
  endtask

  task automatic test_illegal_zc();
    logic [8:0] bad [2] = '{9'd0, 9'd385};
    for (int b = 0; b < 2; b++) begin
      @(negedge clk); start = 1'b1; zc = bad[b];
      @(negedge clk); start = 1'b0;
      checks++; if (err !== 1'b1 || busy !== 1'b0 || rd_en2 !== 1'b0) begin
        errors++; $display("FAIL illegal_zc%0d: err=%b busy=%b rd=%b want 1 0 0", bad[b], err, busy, rd_en2);
      end
      @(negedge clk);
      checks++; if (err !== 1'b0 || busy !== 1'b0 || rd_en2 !== 1'b0) begin
        errors++; $display("FAIL illegal_after%0d: err=%b busy=%b rd=%b want 0 0 0", bad[b], err, busy, rd_en2);
      end
    end
  endtask

  task automatic test_timeout();
    int errc = -1, rds = 0;
    logic b_at = 1'b1;
    @(negedge clk); start = 1'b1; zc = 9'd13; ils_sel = 3'd3;
    @(negedge clk); start = 1'b0;
    checks++; if (rd_en2 !== 1'b1 || ils_selected !== 3'd3) begin errors++; $display("FAIL tmo_req: rd=%b ils=%0d want 1 3", rd_en2, ils_selected); end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rd_en2) rds++;
      if (err) begin errc = c; b_at = busy; break; end
    end
    checks++; if (errc !== 16) begin errors++; $display("FAIL tmo_cycles: err after %0d want 16", errc); end
    checks++; if (b_at !== 1'b0 || rds !== 0) begin errors++; $display("FAIL tmo_state: busy=%b rd_pulses=%0d want 0 0", b_at, rds); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_pulse: err=%b want 0", err); end
    run_job(9'd384, 3'd6, 1'b0);
    checks++; if (n_xfer !== N || n_done !== 1 || ils_seen !== 3'd6) begin
      errors++; $display("FAIL tmo_restart: xfers=%0d dones=%0d ils=%0d want %0d 1 6", n_xfer, n_done, ils_seen, N);
    end
  endtask

  task automatic test_backpressure();
    run_job(9'd13, 3'd2, 1'b1);
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL bp_stable: changes=%0d want 0", stab_err); end
    checks++; if (n_xfer !== N || n_done !== 1) begin errors++; $display("FAIL bp_count: xfers=%0d dones=%0d want %0d 1", n_xfer, n_done, N); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (xi[i] !== 3'(i) || xv[i] !== rom[i] % 9'd13) begin
        errors++; $display("FAIL bp_entry%0d: val=%0d idx=%0d want %0d %0d", i, xv[i], xi[i], rom[i] % 9'd13, i);
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    @(negedge clk); start = 1'b1; zc = 9'd13; ils_sel = 3'd2;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) bg2_out[i] = rom[i];
    bg2_valid = 1'b1;
    @(negedge clk); bg2_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    checks++; if ({busy, shift_valid, ils_selected, shift_idx, done, err} !== '0) begin
      errors++; $display("FAIL mid_reset: busy=%b sv=%b ils=%0d idx=%0d done=%b err=%b want all 0",
                         busy, shift_valid, ils_selected, shift_idx, done, err);
    end
    repeat (20) begin @(negedge clk); if (done || err || rd_en2 || busy) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mid_reset_quiet: active cycles=%0d want 0", bad); end
    run_job(9'd13, 3'd5, 1'b0);
    checks++; if (ils_seen !== 3'd5 || xi[0] !== 3'd0) begin errors++; $display("FAIL restart: ils=%0d idx0=%0d want 5 0", ils_seen, xi[0]); end
    checks++; if (n_xfer !== N || n_done !== 1 || xv[7] !== 9'd5) begin
      errors++; $display("FAIL restart_job: xfers=%0d dones=%0d last=%0d want %0d 1 5", n_xfer, n_done, xv[7], N);
    end
  endtask

  initial begin
    test_reset();
    test_first_entry();
    test_mod_values();
    test_illegal_zc();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
